// File: rtl/move_resolver.sv
// Move resolver: looks up the selected move, rolls against its accuracy using an
// internal LFSR and holds the hit/crit/damage result until the datapath acks it.
module move_resolver #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter logic [3:0] CRIT_ROLL = 4'h0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [1:0] move,
    input  logic       target_in,
    input  logic       roll_force_en,
    input  logic [3:0] roll_force,
    output logic       req_ready,
    output logic       res_valid,
    output logic       res_hit,
    output logic       res_crit,
    output logic [3:0] res_dmg,
    output logic       res_target,
    input  logic       res_ack,
    output logic [3:0] tbl_dmg,
    output logic [3:0] tbl_accu
);

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned VAL_W  = 4;
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [VAL_W-1:0]  ACCU_ALWAYS = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROLL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [LFSR_W-1:0] lfsr;
    logic [1:0]        move_q, move_nxt;
    logic              target_q, target_nxt;
    logic              ready_nxt, valid_nxt, hit_nxt, crit_nxt, res_target_nxt;
    logic [VAL_W-1:0]  dmg_nxt;

    logic [VAL_W-1:0]  cap_dmg, cap_accu, roll_c, sat_dmg;
    logic [VAL_W:0]    dbl_dmg;
    logic              hit_c, crit_c;

    // Fixed move table, {damage, accuracy}
    function automatic logic [2*VAL_W-1:0] tbl_lookup(input logic [1:0] m);
        case (m)
            2'd0:    tbl_lookup = {4'd3, 4'd12};
            2'd1:    tbl_lookup = {4'd5, 4'd10};
            2'd2:    tbl_lookup = {4'd8, 4'd6};
            default: tbl_lookup = {4'd2, 4'd15};
        endcase
    endfunction

    assign {tbl_dmg, tbl_accu} = tbl_lookup(move);
    assign {cap_dmg, cap_accu} = tbl_lookup(move_q);

    // Roll evaluation against the captured move
    assign roll_c  = roll_force_en ? roll_force : lfsr[VAL_W-1:0];
    assign hit_c   = (cap_accu == ACCU_ALWAYS) || (roll_c < cap_accu);
    assign crit_c  = hit_c && (roll_c == CRIT_ROLL);
    assign dbl_dmg = {cap_dmg, 1'b0};
    assign sat_dmg = (dbl_dmg > 5'd15) ? 4'hF : dbl_dmg[VAL_W-1:0];

    // LFSR free-runs on every edge, x^8+x^6+x^5+x^4+1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            move_q     <= 2'd0;
            target_q   <= 1'b0;
            req_ready  <= 1'b1;
            res_valid  <= 1'b0;
            res_hit    <= 1'b0;
            res_crit   <= 1'b0;
            res_dmg    <= 4'd0;
            res_target <= 1'b0;
        end else begin
            state      <= state_nxt;
            move_q     <= move_nxt;
            target_q   <= target_nxt;
            req_ready  <= ready_nxt;
            res_valid  <= valid_nxt;
            res_hit    <= hit_nxt;
            res_crit   <= crit_nxt;
            res_dmg    <= dmg_nxt;
            res_target <= res_target_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        move_nxt       = move_q;
        target_nxt     = target_q;
        valid_nxt      = res_valid;
        hit_nxt        = res_hit;
        crit_nxt       = res_crit;
        dmg_nxt        = res_dmg;
        res_target_nxt = res_target;

        case (state)
            IDLE: begin
                if (req) begin
                    move_nxt   = move;
                    target_nxt = target_in;
                    state_nxt  = ROLL;
                end
            end
            ROLL: begin
                valid_nxt      = 1'b1;
                hit_nxt        = hit_c;
                crit_nxt       = crit_c;
                dmg_nxt        = !hit_c ? 4'd0 : (crit_c ? sat_dmg : cap_dmg);
                res_target_nxt = target_q;
                state_nxt      = HOLD;
            end
            HOLD: begin
                if (res_ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        ready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_move_resolver.sv
// Self-checking bench for move_resolver: randomized turns checked against a
// table/arithmetic reference model with a separately stepped LFSR.
module tb_move_resolver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req;
    logic [1:0] move;
    logic       target_in;
    logic       roll_force_en;
    logic [3:0] roll_force;
    logic       req_ready;
    logic       res_valid;
    logic       res_hit;
    logic       res_crit;
    logic [3:0] res_dmg;
    logic       res_target;
    logic       res_ack;
    logic [3:0] tbl_dmg;
    logic [3:0] tbl_accu;

    int n_vec = 0;
    int n_bad = 0;

    int dmg_tbl[4]  = '{3, 5, 8, 2};
    int accu_tbl[4] = '{12, 10, 6, 15};

    logic [7:0] m_lfsr;

    move_resolver dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .move         (move),
        .target_in    (target_in),
        .roll_force_en(roll_force_en),
        .roll_force   (roll_force),
        .req_ready    (req_ready),
        .res_valid    (res_valid),
        .res_hit      (res_hit),
        .res_crit     (res_crit),
        .res_dmg      (res_dmg),
        .res_target   (res_target),
        .res_ack      (res_ack),
        .tbl_dmg      (tbl_dmg),
        .tbl_accu     (tbl_accu)
    );

    always #5 clk = ~clk;

    // Golden LFSR: shift left, parity of taps 7,5,4,3 enters bit 0
    always @(posedge clk) begin
        if (!reset_n) m_lfsr <= 8'hA5;
        else          m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {hit, crit, dmg} from the move table and a roll value
    function automatic logic [5:0] ref_resolve(input int mv, input int roll);
        int  base, acc, dmg;
        logic hit, crit;
        base = dmg_tbl[mv];
        acc  = accu_tbl[mv];
        hit  = (acc == 15) || (roll < acc);
        crit = hit && (roll == 0);
        if (!hit)      dmg = 0;
        else if (crit) dmg = (2 * base > 15) ? 15 : 2 * base;
        else           dmg = base;
        return {hit, crit, 4'(dmg)};
    endfunction

    // One full turn; entered and left at a negedge with the DUT in IDLE
    task automatic do_txn(input logic [1:0] mv, input logic tgt, input logic fen,
                          input logic [3:0] froll, input int ack_delay, input logic hold_req);
        logic [5:0] exp;
        logic [3:0] roll;
        move = mv; target_in = tgt; roll_force_en = fen; roll_force = froll;
        req = 1'b1; res_ack = 1'b0;
        #1;
        chk("ready_idle", 8'(req_ready), 8'd1);
        @(posedge clk); @(negedge clk);
        roll = fen ? froll : m_lfsr[3:0];
        exp  = ref_resolve(int'(mv), int'(roll));
        chk("valid_roll", 8'(res_valid), 8'd0);
        chk("ready_roll", 8'(req_ready), 8'd0);
        move = 2'($urandom); target_in = 1'($urandom);
        req = hold_req; res_ack = 1'($urandom);
        @(posedge clk); @(negedge clk);
        res_ack = 1'b0;
        chk("valid_hold", 8'(res_valid), 8'd1);
        chk("hit", 8'(res_hit), 8'(exp[5]));
        chk("crit", 8'(res_crit), 8'(exp[4]));
        chk("dmg", 8'(res_dmg), 8'(exp[3:0]));
        chk("target", 8'(res_target), 8'(tgt));
        chk("ready_hold", 8'(req_ready), 8'd0);
        for (int i = 0; i < ack_delay; i++) begin
            move = 2'($urandom); target_in = 1'($urandom); roll_force = 4'($urandom);
            #1;
            chk("tbl_dmg_live", 8'(tbl_dmg), 8'(dmg_tbl[move]));
            @(posedge clk); @(negedge clk);
            chk("valid_wait", 8'(res_valid), 8'd1);
            chk("dmg_wait", 8'(res_dmg), 8'(exp[3:0]));
        end
        res_ack = 1'b1; req = hold_req;
        @(posedge clk); @(negedge clk);
        res_ack = 1'b0; req = 1'b0;
        chk("valid_after_ack", 8'(res_valid), 8'd0);
        chk("ready_after_ack", 8'(req_ready), 8'd1);
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; move = 2'd0; target_in = 1'b0;
        roll_force_en = 1'b0; roll_force = 4'd0; res_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 8'(req_ready), 8'd1);
        chk("rst_valid", 8'(res_valid), 8'd0);
        chk("rst_dmg", 8'(res_dmg), 8'd0);
        chk("rst_hit", 8'(res_hit), 8'd0);
        reset_n = 1'b1;

        // LFSR-driven rolls straight out of reset
        for (int i = 0; i < 4; i++) do_txn(2'(i), 1'($urandom), 1'b0, 4'd0, 0, 1'b0);

        // Table sweep without req
        for (int m = 0; m < 4; m++) begin
            move = 2'(m);
            #1;
            chk("tbl_dmg", 8'(tbl_dmg), 8'(dmg_tbl[m]));
            chk("tbl_accu", 8'(tbl_accu), 8'(accu_tbl[m]));
        end
        @(negedge clk);

        // Directed turns: plain hit, saturated crit, crit, miss, always-hit
        do_txn(2'd1, 1'b0, 1'b1, 4'd4, 2, 1'b0);
        do_txn(2'd2, 1'b1, 1'b1, 4'd0, 1, 1'b0);
        do_txn(2'd0, 1'b0, 1'b1, 4'd0, 0, 1'b0);
        do_txn(2'd2, 1'b1, 1'b1, 4'd6, 0, 1'b0);
        do_txn(2'd3, 1'b0, 1'b1, 4'd14, 0, 1'b0);

        // req held high across three back-to-back turns
        for (int i = 0; i < 3; i++) do_txn(2'(i), 1'(i), 1'b1, 4'(i + 3), 0, 1'b1);

        // Reset while holding a result; reset beats req and ack
        req = 1'b1; move = 2'd1; target_in = 1'b1; roll_force_en = 1'b1; roll_force = 4'd4;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("pre_rst_valid", 8'(res_valid), 8'd1);
        reset_n = 1'b0; req = 1'b1; res_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("hold_rst_valid", 8'(res_valid), 8'd0);
        chk("hold_rst_dmg", 8'(res_dmg), 8'd0);
        chk("hold_rst_target", 8'(res_target), 8'd0);
        chk("hold_rst_ready", 8'(req_ready), 8'd1);
        reset_n = 1'b1; req = 1'b0; res_ack = 1'b0;

        // Golden-LFSR rolls after mid-run reset
        for (int i = 0; i < 3; i++) do_txn(2'($urandom), 1'($urandom), 1'b0, 4'd0, 0, 1'b0);

        // Randomized turns with idle gaps
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                req = 1'b0; res_ack = 1'($urandom);
                @(posedge clk); @(negedge clk);
                res_ack = 1'b0;
            end
            do_txn(2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
